// File: rtl/fir_pkg.sv
// Shared types and sizing helpers for the FIR MAC sequencer.
package fir_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MAC  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int DEF_TAPS = 4;
    localparam int DEF_DW   = 4;

    // Sum of TAPS full-width signed products cannot overflow this width.
    function automatic int acc_width(input int dw, input int taps);
        return 2 * dw + $clog2(taps);
    endfunction

endpackage

// File: rtl/fir_mac_sequencer_if.sv
// Sample stream, result stream and coefficient write port of the FIR sequencer.
interface fir_mac_sequencer_if
    import fir_pkg::*;
#(
    parameter int TAPS = DEF_TAPS,
    parameter int DW   = DEF_DW
);
    localparam int AW = $clog2(TAPS);

    logic [DW-1:0] in_data;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] out_data;
    logic          out_valid;
    logic          out_ready;
    logic          cfg_we;
    logic [AW-1:0] cfg_addr;
    logic [DW-1:0] cfg_data;

    modport master (
        output in_data, in_valid, out_ready, cfg_we, cfg_addr, cfg_data,
        input  in_ready, out_data, out_valid
    );

    modport slave (
        input  in_data, in_valid, out_ready, cfg_we, cfg_addr, cfg_data,
        output in_ready, out_data, out_valid
    );

endinterface

// File: rtl/booth_mult.sv
// Combinational radix-2 Booth multiplier, signed DW x DW -> 2*DW.
// No latency, no flow control.
module booth_mult #(
    parameter int DW = 4
) (
    input  logic signed [DW-1:0]   a,
    input  logic signed [DW-1:0]   b,
    output logic signed [2*DW-1:0] p
);

    logic signed [2*DW-1:0] mcand;
    logic signed [2*DW-1:0] sum;
    logic                   prev;

    // Recode multiplier bit pairs: 01 adds, 10 subtracts the shifted multiplicand.
    always_comb begin
        mcand = {{DW{b[DW-1]}}, b};
        sum   = '0;
        prev  = 1'b0;
        for (int i = 0; i < DW; i++) begin
            case ({a[i], prev})
                2'b01:   sum = sum + (mcand <<< i);
                2'b10:   sum = sum - (mcand <<< i);
                default: sum = sum;
            endcase
            prev = a[i];
        end
    end

    assign p = sum;

endmodule

// File: rtl/fir_mac_sequencer.sv
// Time-multiplexed FIR: one shared multiplier, one tap per cycle, result TAPS+1 cycles after accept.
// in_ready only in IDLE; the result holds in DONE until out_ready.
module fir_mac_sequencer
    import fir_pkg::*;
#(
    parameter int TAPS  = DEF_TAPS,
    parameter int DW    = DEF_DW,
    parameter int SHIFT = 0
) (
    input  logic              clk,
    input  logic              rst,
    fir_mac_sequencer_if.slave bus
);

    localparam int AW   = $clog2(TAPS);
    localparam int ACCW = acc_width(DW, TAPS);

    localparam logic signed [DW-1:0] MAX_VAL = {1'b0, {(DW-1){1'b1}}};
    localparam logic signed [DW-1:0] MIN_VAL = {1'b1, {(DW-1){1'b0}}};

    state_t state_q;
    state_t state_d;

    logic signed [DW-1:0]   x_q    [TAPS];
    logic signed [DW-1:0]   coef_q [TAPS];
    logic signed [ACCW-1:0] acc_q;
    logic [AW-1:0]          idx_q;
    logic [DW-1:0]          out_data_q;
    logic                   out_valid_q;

    logic in_ready_c;
    logic accept;
    logic cfg_en;
    logic mac_en;
    logic hs;
    logic last_tap;

    logic signed [2*DW-1:0] prod;
    logic signed [ACCW-1:0] acc_sum;
    logic signed [ACCW-1:0] shifted;
    logic [ACCW-DW:0]       hi;
    logic [DW-1:0]          sat_val;

    assign last_tap = (idx_q == AW'(TAPS - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (bus.in_valid) state_d = MAC;
            MAC:     if (last_tap) state_d = DONE;
            DONE:    if (bus.out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        in_ready_c = 1'b0;
        accept     = 1'b0;
        cfg_en     = 1'b0;
        mac_en     = 1'b0;
        hs         = 1'b0;
        case (state_q)
            IDLE: begin
                in_ready_c = 1'b1;
                accept     = bus.in_valid;
                cfg_en     = bus.cfg_we;
            end
            MAC:     mac_en = 1'b1;
            DONE:    hs     = out_valid_q && bus.out_ready;
            default: ;
        endcase
    end

    booth_mult #(
        .DW (DW)
    ) u_mult (
        .a (coef_q[idx_q]),
        .b (x_q[idx_q]),
        .p (prod)
    );

    // The final tap's product is folded in combinationally so the result registers on the MAC->DONE edge.
    always_comb begin
        acc_sum = acc_q + {{(ACCW-2*DW){prod[2*DW-1]}}, prod};
        shifted = acc_sum >>> SHIFT;
        hi      = shifted[ACCW-1:DW-1];
        if ((&hi) || !(|hi)) begin
            sat_val = shifted[DW-1:0];
        end else if (shifted[ACCW-1]) begin
            sat_val = MIN_VAL;
        end else begin
            sat_val = MAX_VAL;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < TAPS; i++) begin
                x_q[i]    <= '0;
                coef_q[i] <= '0;
            end
            acc_q       <= '0;
            idx_q       <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
        end else begin
            if (cfg_en) begin
                coef_q[bus.cfg_addr] <= bus.cfg_data;
            end
            if (accept) begin
                for (int i = TAPS - 1; i > 0; i--) begin
                    x_q[i] <= x_q[i-1];
                end
                x_q[0] <= bus.in_data;
                acc_q  <= '0;
                idx_q  <= '0;
            end
            if (mac_en) begin
                acc_q <= acc_sum;
                idx_q <= idx_q + AW'(1);
                if (last_tap) begin
                    out_data_q  <= sat_val;
                    out_valid_q <= 1'b1;
                end
            end
            if (hs) begin
                out_valid_q <= 1'b0;
            end
        end
    end

    assign bus.in_ready  = in_ready_c;
    assign bus.out_data  = out_data_q;
    assign bus.out_valid = out_valid_q;

endmodule

// File: tb/tb_fir_mac_sequencer.sv
// Two sequencers (SHIFT 0 and 2) on identical stimulus, checked against a reference FIR model.
module tb_fir_mac_sequencer;
    import fir_pkg::*;

    localparam int TAPS = 4;
    localparam int DW   = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [DW-1:0] in_data   = '0;
    logic          in_valid  = 1'b0;
    logic          out_ready = 1'b1;
    logic          cfg_we    = 1'b0;
    logic [1:0]    cfg_addr  = '0;
    logic [DW-1:0] cfg_data  = '0;

    fir_mac_sequencer_if #(.TAPS(TAPS), .DW(DW)) bus0 ();
    fir_mac_sequencer_if #(.TAPS(TAPS), .DW(DW)) bus1 ();

    assign bus0.in_data   = in_data;
    assign bus0.in_valid  = in_valid;
    assign bus0.out_ready = out_ready;
    assign bus0.cfg_we    = cfg_we;
    assign bus0.cfg_addr  = cfg_addr;
    assign bus0.cfg_data  = cfg_data;
    assign bus1.in_data   = in_data;
    assign bus1.in_valid  = in_valid;
    assign bus1.out_ready = out_ready;
    assign bus1.cfg_we    = cfg_we;
    assign bus1.cfg_addr  = cfg_addr;
    assign bus1.cfg_data  = cfg_data;

    fir_mac_sequencer #(.TAPS(TAPS), .DW(DW), .SHIFT(0)) dut0 (.clk(clk), .rst(rst), .bus(bus0));
    fir_mac_sequencer #(.TAPS(TAPS), .DW(DW), .SHIFT(2)) dut1 (.clk(clk), .rst(rst), .bus(bus1));

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    function automatic int sdat(input logic [DW-1:0] v);
        return int'($signed(v));
    endfunction

    function automatic int sat(input int v);
        if (v > 7)  return 7;
        if (v < -8) return -8;
        return v;
    endfunction

    // Reference model and scoreboard
    int  cyc = 0;
    int  mx[TAPS];
    int  mc[TAPS];
    int  q0[$];
    int  q1[$];
    int  qa[$];
    int  cur0 = 0;
    int  cur1 = 0;
    int  busy = 0;
    int  last_acc = -1;
    bit  pv0 = 0, pv1 = 0, hs0 = 0, hs1 = 0;

    always @(negedge clk) begin
        int acc;
        cyc++;
        if (rst) begin
            for (int i = 0; i < TAPS; i++) begin
                mx[i] = 0;
                mc[i] = 0;
            end
            q0.delete(); q1.delete(); qa.delete();
            busy = 0; last_acc = -1;
            pv0 = 0; pv1 = 0; hs0 = 0; hs1 = 0;
        end else begin
            if (hs0) check("vld_drop0", int'(bus0.out_valid), 0);
            if (hs1) check("vld_drop1", int'(bus1.out_valid), 0);

            if (bus0.out_valid && !pv0) begin
                if (q0.size() == 0) check("spurious0", 1, 0);
                else begin
                    cur0 = q0.pop_front();
                    check("data0", sdat(bus0.out_data), cur0);
                    if (qa.size() != 0) check("latency", cyc - qa.pop_front(), TAPS + 1);
                end
            end else if (bus0.out_valid) begin
                check("hold0", sdat(bus0.out_data), cur0);
            end
            if (bus1.out_valid && !pv1) begin
                if (q1.size() == 0) check("spurious1", 1, 0);
                else begin
                    cur1 = q1.pop_front();
                    check("data1", sdat(bus1.out_data), cur1);
                end
            end else if (bus1.out_valid) begin
                check("hold1", sdat(bus1.out_data), cur1);
            end

            if (bus0.out_valid) check("rdy_done0", int'(bus0.in_ready), 0);
            if (bus1.out_valid) check("rdy_done1", int'(bus1.in_ready), 0);
            if (busy > 0) begin
                check("rdy_mac0", int'(bus0.in_ready), 0);
                check("rdy_mac1", int'(bus1.in_ready), 0);
                busy--;
            end

            hs0 = bus0.out_valid && out_ready;
            hs1 = bus1.out_valid && out_ready;
            pv0 = bus0.out_valid;
            pv1 = bus1.out_valid;

            if (!in_valid) last_acc = -1;
            if (cfg_we && bus0.in_ready) mc[cfg_addr] = sdat(cfg_data);
            if (in_valid && bus0.in_ready) begin
                if (last_acc >= 0) check("tput", cyc - last_acc, TAPS + 2);
                last_acc = cyc;
                for (int i = TAPS - 1; i > 0; i--) mx[i] = mx[i-1];
                mx[0] = sdat(in_data);
                acc = 0;
                for (int i = 0; i < TAPS; i++) acc += mc[i] * mx[i];
                q0.push_back(sat(acc));
                q1.push_back(sat(acc >>> 2));
                qa.push_back(cyc);
                busy = TAPS + 1;
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_done();
        int n = 0;
        @(negedge clk);
        while ((q0.size() != 0 || q1.size() != 0 || !bus0.in_ready) && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) check("drain_timeout", 0, 1);
        @(posedge clk);
        #1;
    endtask

    task automatic write_coef(input int a, input int d);
        wait_done();
        cfg_we   = 1'b1;
        cfg_addr = a[1:0];
        cfg_data = d[DW-1:0];
        tick(1);
        cfg_we   = 1'b0;
    endtask

    task automatic send(input int d, input bit keep);
        int n = 0;
        in_data  = d[DW-1:0];
        in_valid = 1'b1;
        @(negedge clk);
        while (!bus0.in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) check("send_timeout", 0, 1);
        tick(1);
        if (!keep) in_valid = 1'b0;
    endtask

    task automatic check_reset_outputs();
        @(negedge clk);
        check("rst_rdy0",  int'(bus0.in_ready), 1);
        check("rst_vld0",  int'(bus0.out_valid), 0);
        check("rst_data0", sdat(bus0.out_data), 0);
        check("rst_rdy1",  int'(bus1.in_ready), 1);
        check("rst_vld1",  int'(bus1.out_valid), 0);
        check("rst_data1", sdat(bus1.out_data), 0);
        tick(1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int n;
        rst = 1'b1;
        tick(3);
        rst = 1'b0;
        check_reset_outputs();

        // Moving sum of ones, back-to-back samples
        for (int i = 0; i < TAPS; i++) write_coef(i, 1);
        for (int k = 0; k < 5; k++) send(1, k < 4);
        in_valid = 1'b0;
        wait_done();

        // Saturation corners
        write_coef(0, 7);
        for (int i = 1; i < TAPS; i++) write_coef(i, 0);
        send(7, 0);
        write_coef(0, -8);
        send(7, 0);
        send(-8, 0);
        wait_done();

        // Coefficient write coinciding with sample acceptance
        cfg_we = 1'b1; cfg_addr = 2'd0; cfg_data = 4'd2;
        send(3, 0);
        cfg_we = 1'b0;
        wait_done();

        // Output backpressure: result holds, input ignored
        out_ready = 1'b0;
        send(1, 0);
        n = 0;
        @(negedge clk);
        while (!bus0.out_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (n >= 20) check("vld_timeout", 0, 1);
        tick(1);
        for (int k = 0; k < 10; k++) begin
            in_valid = ~in_valid;
            in_data  = 4'd5;
            tick(1);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        wait_done();

        // Coefficient writes during MAC are dropped
        write_coef(0, 1);
        write_coef(1, 0);
        send(2, 0);
        cfg_we = 1'b1; cfg_addr = 2'd1; cfg_data = 4'd5;
        tick(2);
        cfg_we = 1'b0;
        send(3, 0);
        wait_done();

        // Reset mid-pass aborts the result
        send(1, 0);
        tick(1);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        check_reset_outputs();
        tick(10);
        send(5, 0);
        wait_done();

        // Shifted output with saturation, from a clean delay line
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        tick(1);
        for (int i = 0; i < TAPS; i++) write_coef(i, 3);
        for (int k = 0; k < 4; k++) send(4, k < 3);
        in_valid = 1'b0;
        wait_done();

        // Random samples with coefficient writes riding on each acceptance
        for (int k = 0; k < 12; k++) begin
            if ($urandom_range(0, 1) == 1) begin
                cfg_we   = 1'b1;
                cfg_addr = 2'($urandom_range(0, 3));
                cfg_data = 4'($urandom_range(0, 15));
            end
            send(int'($urandom_range(0, 15)) - 8, 1'b1);
            cfg_we = 1'b0;
        end
        in_valid = 1'b0;
        wait_done();

        check("queues_empty", q0.size() + q1.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
